cv32e40x_ex_fu_sched: RTL and testbench
=======================================

Name: cv32e40x_ex_fu_sched

Overview:
- Scheduler for the EX-stage functional units ALU, MUL, DIV, LSU and CSR.
- Takes the single instruction held in the ID/EX register and drives the request valid of exactly one unit. Multicycle units (MUL, DIV) are tracked with a small FSM.
- Produces ex_ready/ex_valid, the EX/WB capture enable and the registered WB instr_valid.
- Applies controller kill/halt uniformly to every unit. Also provides a per-instruction EX occupancy counter for performance monitoring.

Parameters:
- CNT_W, 6, width of the EX occupancy cycle counter (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid_i  in  1  ID/EX register holds a valid instruction
- fu_sel_i  in  5  one-hot unit select {CSR,LSU,DIV,MUL,ALU} (bit0=ALU); all-zero = ALU
- exc_i  in  1  instruction carries an earlier IF/ID exception or trigger match (NOP in EX)
- kill_ex_i  in  1  controller kill of EX
- halt_ex_i  in  1  controller halt of EX
- unit_ready_i  in  5  per-unit ready (same bit order)
- unit_valid_i  in  5  per-unit result valid (LSU bit = lsu_valid)
- wb_ready_i  in  1  WB stage ready
- fu_valid_o  out  5  per-unit request valid, gated
- ex_ready_o  out  1  EX ready for new instruction
- ex_valid_o  out  1  EX has a valid result for WB
- ex_wb_we_o  out  1  capture enable for the EX/WB payload register
- wb_instr_valid_o  out  1  registered EX/WB instr_valid
- mc_busy_o  out  1  multicycle op outstanding (perf stall)
- ex_cycles_o  out  CNT_W  cycles the current instruction has occupied EX

Behaviour:
- Definitions:
  - iv = instr_valid_i & !kill_ex_i & !halt_ex_i.
  - sel = fu_sel_i, or 5'b00001 if fu_sel_i==0.
  - exc_i=1 forces fu_valid_o=0.
- fu_valid_o = sel & {5{iv & !exc_i}}. Purely combinational; no registered request.
- ex_valid_o = iv & (exc_i | |(sel & unit_valid_i)).
- ex_ready_o = kill_ex_i | (!halt_ex_i & wb_ready_i & &(unit_ready_i)).
- ex_wb_we_o = ex_valid_o & wb_ready_i.
- wb_instr_valid_o:
  - Reset 0.
  - Set to 1 when ex_wb_we_o.
  - Else cleared to 0 when wb_ready_i.
  - Else held.
- FSM states IDLE, MC_BUSY, MC_DONE; reset IDLE.
  - IDLE -> MC_BUSY: iv & !exc_i & sel[MUL|DIV] & !unit_valid_i[sel].
  - IDLE stays IDLE: single-cycle result or exception completes in the same cycle.
  - MC_BUSY -> MC_DONE: unit_valid_i[sel] & !wb_ready_i.
  - MC_BUSY -> IDLE: unit_valid_i[sel] & wb_ready_i.
  - MC_DONE -> IDLE: wb_ready_i.
  - Any state -> IDLE next cycle on kill_ex_i or halt_ex_i. Request valid drops, so the unit aborts; a halted op restarts from scratch on release.
  - Any state -> IDLE if instr_valid_i=0.
- mc_busy_o = (state != IDLE). Reset 0.
- ex_cycles_o:
  - Reset 0.
  - Increments each cycle instr_valid_i=1 and no ex_wb_we_o; saturates at 2^CNT_W-1.
  - Cleared to 0 on ex_wb_we_o, kill_ex_i, or instr_valid_i=0.
  - Halt does not clear it; it counts halted cycles.
- Simultaneous kill & halt: kill wins for ex_ready_o (=1); outputs are otherwise as for kill.
- Multi-hot fu_sel_i is illegal: covered by an assertion, and the bench never drives it.
- Reset mid-op: all state, counter and wb_instr_valid_o return to 0/IDLE asynchronously.
- Assertions:
  - $onehot0(fu_valid_o).
  - ex_valid_o implies !kill_ex_i.
  - MC_DONE implies sel is MUL or DIV.

Decomposition:
- cv32e40x_pkg gains:
  - typedef enum fu_idx_e {FU_ALU=0, FU_MUL, FU_DIV, FU_LSU, FU_CSR}
  - localparam FU_NUM=5
  - typedef enum ex_sched_state_e {EX_IDLE, EX_MC_BUSY, EX_MC_DONE}
- One sub-module, cv32e40x_sat_counter (width param, inc/clr inputs), reusable by the perf counters.

Test Plan:
- ALU single-cycle: iv=1, sel=ALU, unit_valid=5'h1f, wb_ready=1 -> fu_valid_o=5'h01, ex_valid_o=1, ex_wb_we_o=1, wb_instr_valid_o=1 next cycle, state IDLE, ex_cycles_o=0.
- DIV 34-cycle: sel=DIV, unit_valid[DIV] rises on cycle 34 with wb_ready=0 for 3 cycles:
  - mc_busy_o high from cycle 1.
  - State MC_DONE for 3 cycles, ex_valid_o held.
  - ex_wb_we_o on the wb_ready cycle.
  - ex_cycles_o=36 before clearing to 0.
- Kill during MUL busy (cycle 2): ex_ready_o=1 and fu_valid_o=0 the same cycle; next cycle state IDLE, ex_cycles_o=0, wb_instr_valid_o=0 once wb_ready=1.
- Halt during DIV for 5 cycles then release:
  - fu_valid_o=0 and ex_ready_o=0 while halted.
  - State IDLE while halted, then MC_BUSY again after release.
  - ex_cycles_o keeps counting through the halt.
- Exception NOP: exc_i=1, sel=LSU, iv=1 -> fu_valid_o=0 (no bus request), ex_valid_o=1, ex_wb_we_o=1.
- Counter saturation: CNT_W=6, DIV held busy 70 cycles -> ex_cycles_o sticks at 63; asynchronous reset mid-op -> all outputs 0 immediately.

Source files
------------

// File: rtl/cv32e40x_ex_fu_sched_pkg.sv
// Shared types for the EX-stage functional-unit scheduler: unit indices,
// scheduler FSM states and the unit-select normalisation helper.
package cv32e40x_ex_fu_sched_pkg;

  localparam int unsigned FU_NUM = 5;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_LSU = 3'd3,
    FU_CSR = 3'd4
  } fu_idx_e;

  typedef enum logic [1:0] {
    EX_IDLE    = 2'd0,
    EX_MC_BUSY = 2'd1,
    EX_MC_DONE = 2'd2
  } ex_sched_state_e;

  // Decoder emits all-zero for plain ALU ops; map that onto the ALU bit.
  function automatic logic [FU_NUM-1:0] fu_sel_norm(input logic [FU_NUM-1:0] fu_sel);
    fu_sel_norm = (fu_sel == '0) ? FU_NUM'(1) : fu_sel;
  endfunction

endpackage

// File: rtl/cv32e40x_ex_fu_sched_if.sv
// Request/response handshake between the EX scheduler and its functional units.
interface cv32e40x_ex_fu_sched_if;
  import cv32e40x_ex_fu_sched_pkg::*;

  logic [FU_NUM-1:0] fu_valid;
  logic [FU_NUM-1:0] unit_ready;
  logic [FU_NUM-1:0] unit_valid;

  modport master (output fu_valid, input unit_ready, input unit_valid);
  modport slave  (input fu_valid, output unit_ready, output unit_valid);

endinterface

// File: rtl/cv32e40x_ex_fu_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module cv32e40x_sat_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40x_ex_fu_sched.sv
// EX-stage scheduler: steers the ID/EX instruction to one functional unit,
// tracks multicycle MUL/DIV ops and generates the EX/WB handshake.
module cv32e40x_ex_fu_sched
  import cv32e40x_ex_fu_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid_i,
  input  logic [FU_NUM-1:0]          fu_sel_i,
  input  logic                       exc_i,
  input  logic                       kill_ex_i,
  input  logic                       halt_ex_i,
  input  logic                       wb_ready_i,
  cv32e40x_ex_fu_sched_if.master     fu_if,
  output logic                       ex_ready_o,
  output logic                       ex_valid_o,
  output logic                       ex_wb_we_o,
  output logic                       wb_instr_valid_o,
  output logic                       mc_busy_o,
  output logic [CNT_W-1:0]           ex_cycles_o
);

  ex_sched_state_e   state_q, state_d;
  logic              wb_instr_valid_q, wb_instr_valid_d;
  logic              iv;
  logic [FU_NUM-1:0] sel;
  logic              unit_done;
  logic              sel_mc;

  assign iv        = instr_valid_i & ~kill_ex_i & ~halt_ex_i;
  assign sel       = fu_sel_norm(fu_sel_i);
  assign unit_done = |(sel & fu_if.unit_valid);
  assign sel_mc    = sel[FU_MUL] | sel[FU_DIV];

  // Exceptions travel as NOPs: no unit sees a request, but EX still completes.
  assign fu_if.fu_valid = sel & {FU_NUM{iv & ~exc_i}};
  assign ex_valid_o     = iv & (exc_i | unit_done);
  assign ex_ready_o     = kill_ex_i | (~halt_ex_i & wb_ready_i & (&fu_if.unit_ready));
  assign ex_wb_we_o     = ex_valid_o & wb_ready_i;

  always_comb begin
    wb_instr_valid_d = wb_instr_valid_q;
    if (ex_wb_we_o) begin
      wb_instr_valid_d = 1'b1;
    end else if (wb_ready_i) begin
      wb_instr_valid_d = 1'b0;
    end
  end

  // Dropping the request on kill/halt aborts the unit, so the FSM restarts too.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EX_IDLE: begin
        if (iv && !exc_i && sel_mc && !unit_done) state_d = EX_MC_BUSY;
      end
      EX_MC_BUSY: begin
        if (unit_done) state_d = wb_ready_i ? EX_IDLE : EX_MC_DONE;
      end
      EX_MC_DONE: begin
        if (wb_ready_i) state_d = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase
    if (!iv) state_d = EX_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= EX_IDLE;
      wb_instr_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      wb_instr_valid_q <= wb_instr_valid_d;
    end
  end

  assign wb_instr_valid_o = wb_instr_valid_q;
  assign mc_busy_o        = (state_q != EX_IDLE);

  cv32e40x_sat_counter #(
    .WIDTH (CNT_W)
  ) u_ex_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ex_wb_we_o | kill_ex_i | ~instr_valid_i),
    .inc_i (instr_valid_i & ~ex_wb_we_o),
    .cnt_o (ex_cycles_o)
  );

  a_fu_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(fu_if.fu_valid));
  a_valid_not_killed: assert property (@(posedge clk) disable iff (!rst_n)
    ex_valid_o |-> !kill_ex_i);
  a_done_is_mc: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == EX_MC_DONE) |-> sel_mc);

endmodule

// File: tb/tb_cv32e40x_ex_fu_sched.sv
// Self-checking bench for the EX scheduler; WB captures are scored against a
// queue of expected occupancy counts pushed when each instruction is issued.
module tb_cv32e40x_ex_fu_sched;
  import cv32e40x_ex_fu_sched_pkg::*;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instrValid;
  logic [4:0]       fuSel;
  logic             exc;
  logic             killEx;
  logic             haltEx;
  logic             wbReady;
  logic             exReady;
  logic             exValid;
  logic             exWbWe;
  logic             wbInstrValid;
  logic             mcBusy;
  logic [CNT_W-1:0] exCycles;

  int assertCount = 0;
  int failCount   = 0;
  int sbQ[$];

  cv32e40x_ex_fu_sched_if fuIf ();

  cv32e40x_ex_fu_sched #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid_i    (instrValid),
    .fu_sel_i         (fuSel),
    .exc_i            (exc),
    .kill_ex_i        (killEx),
    .halt_ex_i        (haltEx),
    .wb_ready_i       (wbReady),
    .fu_if            (fuIf),
    .ex_ready_o       (exReady),
    .ex_valid_o       (exValid),
    .ex_wb_we_o       (exWbWe),
    .wb_instr_valid_o (wbInstrValid),
    .mc_busy_o        (mcBusy),
    .ex_cycles_o      (exCycles)
  );

  always #5 clk = ~clk;

  // Scoreboard: every EX/WB capture must match the oldest issued instruction
  always @(negedge clk) begin
    if (rst_n && exWbWe) begin
      assertCount++;
      if (sbQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL sb_unexpected_capture: got capture with ex_cycles=%0d, required no capture", exCycles);
      end else begin
        int expCycles;
        expCycles = sbQ.pop_front();
        if (exCycles !== CNT_W'(expCycles)) begin
          failCount++;
          $display("[TB] FAIL sb_ex_cycles: got %0d, required %0d", exCycles, expCycles);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instrValid = 1'b0; fuSel = 5'b0; exc = 1'b0; killEx = 1'b0; haltEx = 1'b0;
    fuIf.unit_valid = 5'b0; fuIf.unit_ready = 5'h1f; wbReady = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    assertCount++;
    if ({mcBusy, wbInstrValid, exValid, exWbWe, fuIf.fu_valid} !== 9'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got busy=%b wbiv=%b exv=%b we=%b fuv=%h, required all 0",
               mcBusy, wbInstrValid, exValid, exWbWe, fuIf.fu_valid);
    end
    assertCount++;
    if (exCycles !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_ex_cycles: got %0d, required 0", exCycles);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    tick();
    instrValid = 1'b1; fuSel = 5'b00001; fuIf.unit_valid = 5'h1f; wbReady = 1'b1;
    sbQ.push_back(0);
    #3;
    assertCount++;
    if ({fuIf.fu_valid, exValid, exWbWe} !== {5'h01, 1'b1, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL alu_issue: got fuv=%h exv=%b we=%b, required fuv=01 exv=1 we=1",
               fuIf.fu_valid, exValid, exWbWe);
    end
    tick();
    idle();
    #3;
    assertCount++;
    if ({wbInstrValid, mcBusy} !== 2'b10 || exCycles !== '0) begin
      failCount++;
      $display("[TB] FAIL alu_after: got wbiv=%b busy=%b cycles=%0d, required wbiv=1 busy=0 cycles=0",
               wbInstrValid, mcBusy, exCycles);
    end
    tick();
    #3;
    assertCount++;
    if (wbInstrValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL alu_wbiv_clear: got %b, required 0", wbInstrValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] selTab [3];
    logic [4:0] expTab [3];
    selTab = '{5'b00000, 5'b01000, 5'b10000};
    expTab = '{5'b00001, 5'b01000, 5'b10000};
    for (int i = 0; i < 3; i++) begin
      tick();
      instrValid = 1'b1; fuSel = selTab[i]; fuIf.unit_valid = 5'h1f; wbReady = 1'b1;
      sbQ.push_back(0);
      #3;
      assertCount++;
      if (fuIf.fu_valid !== expTab[i] || exWbWe !== 1'b1 || exCycles !== '0) begin
        failCount++;
        $display("[TB] FAIL b2b_%0d: got fuv=%h we=%b cycles=%0d, required fuv=%h we=1 cycles=0",
                 i, fuIf.fu_valid, exWbWe, exCycles, expTab[i]);
      end
    end
    tick();
    idle();
    #3;
    assertCount++;
    if (wbInstrValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_wbiv: got %b, required 1", wbInstrValid);
    end
  endtask

  task automatic test_div();
    for (int c = 0; c <= 36; c++) begin
      tick();
      instrValid = 1'b1; fuSel = 5'b00100;
      fuIf.unit_valid = (c >= 33) ? 5'b00100 : 5'b0;
      wbReady = (c < 33) || (c >= 36);
      if (c == 0) sbQ.push_back(36);
      #3;
      if (c == 0) begin
        assertCount++;
        if (mcBusy !== 1'b0 || fuIf.fu_valid !== 5'b00100) begin
          failCount++;
          $display("[TB] FAIL div_issue: got busy=%b fuv=%h, required busy=0 fuv=04", mcBusy, fuIf.fu_valid);
        end
      end
      if (c >= 1 && c <= 33) begin
        assertCount++;
        if (dut.state_q !== EX_MC_BUSY || mcBusy !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL div_busy_c%0d: got state=%0d busy=%b, required state=1 busy=1", c, dut.state_q, mcBusy);
        end
      end
      if (c >= 34) begin
        assertCount++;
        if (dut.state_q !== EX_MC_DONE) begin
          failCount++;
          $display("[TB] FAIL div_done_c%0d: got state=%0d, required 2", c, dut.state_q);
        end
      end
      if (c >= 33) begin
        assertCount++;
        if (exValid !== 1'b1 || exWbWe !== (c == 36)) begin
          failCount++;
          $display("[TB] FAIL div_valid_c%0d: got exv=%b we=%b, required exv=1 we=%b", c, exValid, exWbWe, (c == 36));
        end
      end
      if (c == 36) begin
        assertCount++;
        if (exCycles !== CNT_W'(36)) begin
          failCount++;
          $display("[TB] FAIL div_cycles: got %0d, required 36", exCycles);
        end
      end
    end
    tick();
    idle();
    #3;
    assertCount++;
    if (exCycles !== '0 || mcBusy !== 1'b0 || wbInstrValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL div_after: got cycles=%0d busy=%b wbiv=%b, required 0 0 1", exCycles, mcBusy, wbInstrValid);
    end
  endtask

  task automatic test_kill();
    for (int c = 0; c <= 2; c++) begin
      tick();
      instrValid = 1'b1; fuSel = 5'b00010; fuIf.unit_valid = 5'b0;
      wbReady = (c < 2) ? 1'b1 : 1'b0;
      fuIf.unit_ready = (c < 2) ? 5'h1d : 5'h1f;
      killEx = (c == 2);
      #3;
      if (c == 1) begin
        assertCount++;
        if (mcBusy !== 1'b1 || fuIf.fu_valid !== 5'b00010 || exReady !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL kill_pre: got busy=%b fuv=%h rdy=%b, required 1 02 0", mcBusy, fuIf.fu_valid, exReady);
        end
      end
      if (c == 2) begin
        assertCount++;
        if (exReady !== 1'b1 || fuIf.fu_valid !== 5'b0 || exValid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL kill_same_cycle: got rdy=%b fuv=%h exv=%b, required 1 00 0", exReady, fuIf.fu_valid, exValid);
        end
      end
    end
    tick();
    idle();
    #3;
    assertCount++;
    if (mcBusy !== 1'b0 || exCycles !== '0) begin
      failCount++;
      $display("[TB] FAIL kill_after: got busy=%b cycles=%0d, required 0 0", mcBusy, exCycles);
    end
    tick();
    #3;
    assertCount++;
    if (wbInstrValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL kill_wbiv: got %b, required 0", wbInstrValid);
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c <= 10; c++) begin
      tick();
      instrValid = 1'b1; fuSel = 5'b00100; wbReady = 1'b1; fuIf.unit_ready = 5'h1f;
      haltEx = (c >= 3 && c <= 7);
      fuIf.unit_valid = (c == 10) ? 5'b00100 : 5'b0;
      if (c == 0) sbQ.push_back(10);
      #3;
      if (haltEx) begin
        assertCount++;
        if (fuIf.fu_valid !== 5'b0 || exReady !== 1'b0 || exCycles !== CNT_W'(c)) begin
          failCount++;
          $display("[TB] FAIL halt_c%0d: got fuv=%h rdy=%b cycles=%0d, required 00 0 %0d",
                   c, fuIf.fu_valid, exReady, exCycles, c);
        end
      end
      if (c >= 4 && c <= 8) begin
        assertCount++;
        if (mcBusy !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL halt_idle_c%0d: got busy=%b, required 0", c, mcBusy);
        end
      end
      if (c == 8 || c == 9) begin
        assertCount++;
        if (fuIf.fu_valid !== 5'b00100 || mcBusy !== (c == 9)) begin
          failCount++;
          $display("[TB] FAIL halt_release_c%0d: got fuv=%h busy=%b, required 04 %b", c, fuIf.fu_valid, mcBusy, (c == 9));
        end
      end
    end
    tick();
    idle();
  endtask

  task automatic test_exception();
    tick();
    instrValid = 1'b1; fuSel = 5'b01000; exc = 1'b1; fuIf.unit_valid = 5'b0; wbReady = 1'b1;
    sbQ.push_back(0);
    #3;
    assertCount++;
    if ({fuIf.fu_valid, exValid, exWbWe} !== {5'h00, 1'b1, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL exc_nop: got fuv=%h exv=%b we=%b, required 00 1 1", fuIf.fu_valid, exValid, exWbWe);
    end
    tick();
    idle();
    #3;
    assertCount++;
    if (mcBusy !== 1'b0 || wbInstrValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL exc_after: got busy=%b wbiv=%b, required 0 1", mcBusy, wbInstrValid);
    end
  endtask

  task automatic test_saturation();
    tick();
    instrValid = 1'b1; fuSel = 5'b00001; fuIf.unit_valid = 5'h1f; wbReady = 1'b1;
    sbQ.push_back(0);
    for (int c = 0; c < 70; c++) begin
      tick();
      instrValid = 1'b1; fuSel = 5'b00100; fuIf.unit_valid = 5'b0; wbReady = 1'b0;
      #3;
      if (c == 0 || c == 62 || c == 63 || c == 69) begin
        assertCount++;
        if (exCycles !== CNT_W'((c > 63) ? 63 : c) || wbInstrValid !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL sat_c%0d: got cycles=%0d wbiv=%b, required %0d 1",
                   c, exCycles, wbInstrValid, (c > 63) ? 63 : c);
        end
      end
    end
    rst_n = 1'b0;
    instrValid = 1'b0;
    #1;
    assertCount++;
    if (mcBusy !== 1'b0 || exCycles !== '0 || wbInstrValid !== 1'b0 || exValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got busy=%b cycles=%0d wbiv=%b exv=%b, required all 0",
               mcBusy, exCycles, wbInstrValid, exValid);
    end
    tick();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] starting EX scheduler bench");
    test_reset();
    test_alu();
    test_back_to_back();
    test_div();
    test_kill();
    test_halt();
    test_exception();
    test_saturation();
    tick(); tick();
    assertCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL sb_leftover: got %0d pending captures, required 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
